// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one downstream memory port between fetch and LSQ
module mem_port_arbiter #(
  parameter int width        = 32,
  parameter int max_d_streak = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               i_read,
  input  logic [width-1:0]   i_address,
  output logic               i_resp,
  output logic [width-1:0]   i_rdata,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [width/8-1:0] d_byte_enable,
  input  logic [width-1:0]   d_address,
  input  logic [width-1:0]   d_wdata,
  output logic               d_resp,
  output logic [width-1:0]   d_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [width/8-1:0] mem_byte_enable,
  output logic [width-1:0]   mem_address,
  output logic [width-1:0]   mem_wdata,
  input  logic               mem_resp,
  input  logic [width-1:0]   mem_rdata,
  output logic               busy
);

  localparam logic [3:0] max_streak = 4'(max_d_streak);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t             state, state_next;
  logic [3:0]         streak, streak_next;
  logic               drop, drop_next;
  logic               lat_read, lat_write;
  logic [width/8-1:0] lat_be;
  logic [width-1:0]   lat_addr, lat_wdata;
  logic               d_req, i_elig, grant_i, grant_d;

  // Arbitration: LSQ wins unless a fetch has waited through max_streak LSQ grants
  always_comb begin
    d_req   = d_read | d_write;
    i_elig  = i_read & ~flush;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (d_req && i_elig && streak == max_streak) grant_i = 1'b1;
      else if (d_req)                              grant_d = 1'b1;
      else if (i_elig)                             grant_i = 1'b1;
    end
  end

  // Next state, streak/drop bookkeeping and completion pulses
  always_comb begin
    state_next  = state;
    drop_next   = drop;
    streak_next = streak;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    i_rdata     = '0;
    d_rdata     = '0;
    case (state)
      IDLE: begin
        if (grant_i)      state_next = SERVE_I;
        else if (grant_d) state_next = SERVE_D;
      end
      SERVE_I: begin
        if (flush) drop_next = 1'b1;
        if (mem_resp) begin
          state_next = IDLE;
          drop_next  = 1'b0;
          // a squashed fetch still completes downstream but is not reported
          if (!drop && !flush) begin
            i_resp  = 1'b1;
            i_rdata = mem_rdata;
          end
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_next = IDLE;
          d_resp     = 1'b1;
          d_rdata    = mem_rdata;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!i_read || grant_i)
      streak_next = 4'd0;
    else if (grant_d && streak != max_streak)
      streak_next = streak + 4'd1;
    // reset aborts the transaction without a completion pulse
    if (rst) begin
      i_resp  = 1'b0;
      d_resp  = 1'b0;
      i_rdata = '0;
      d_rdata = '0;
    end
  end

  // State, streak and drop registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      streak <= 4'd0;
      drop   <= 1'b0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
      drop   <= drop_next;
    end
  end

  // Capture the winner's request so the downstream port is stable for the transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant_d) begin
      lat_read  <= d_read & ~d_write;
      lat_write <= d_write;
      lat_be    <= d_byte_enable;
      lat_addr  <= d_address;
      lat_wdata <= d_wdata;
    end else if (grant_i) begin
      lat_read  <= 1'b1;
      lat_write <= 1'b0;
      lat_be    <= '1;
      lat_addr  <= i_address;
      lat_wdata <= '0;
    end
  end

  // Downstream port is driven only while a transaction is outstanding
  always_comb begin
    busy            = (state != IDLE);
    mem_read        = busy & lat_read;
    mem_write       = busy & lat_write;
    mem_byte_enable = busy ? lat_be    : '0;
    mem_address     = busy ? lat_addr  : '0;
    mem_wdata       = busy ? lat_wdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MAXS = 2;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst, flush, i_read, d_read, d_write, mem_resp;
  logic [31:0] i_address, d_address, d_wdata, mem_rdata;
  logic [3:0]  d_byte_enable;
  logic        i_resp, d_resp, mem_read, mem_write, busy;
  logic [31:0] i_rdata, d_rdata, mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable;

  req_t        exp_i_req[$], exp_d_req[$];
  logic [31:0] exp_i_rd[$], exp_d_rd[$];
  int          exp_grant[$];
  int          grant_log[$];
  int          total = 0, bad = 0;
  int          delay_mode = -1;

  mem_port_arbiter #(.width(32), .max_d_streak(MAXS)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h60) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: answers each downstream request after a chosen or random delay
  initial begin : responder
    int left;
    left = -1;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp = 1'b0;
      mem_rdata = '0;
      if (mem_read || mem_write) begin
        if (left < 0) left = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
        if (left == 0) begin
          mem_resp = 1'b1;
          mem_rdata = rd_fn(mem_address);
          left = -1;
        end else left--;
      end else left = -1;
    end
  end

  // Monitor: checks responses and downstream requests, and predicts each grant
  initial begin : monitor
    logic [69:0] act, cur;
    logic        in_txn, m_busy, dq, ie;
    int          src, streak_m;
    in_txn = 1'b0; m_busy = 1'b0; streak_m = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (i_resp) begin
        if (exp_i_rd.size() == 0) check("i_resp_unexpected", 72'(i_resp), 72'(0));
        else check("i_rdata", 72'(i_rdata), 72'(exp_i_rd.pop_front()));
      end
      if (d_resp) begin
        if (exp_d_rd.size() == 0) check("d_resp_unexpected", 72'(d_resp), 72'(0));
        else check("d_rdata", 72'(d_rdata), 72'(exp_d_rd.pop_front()));
      end
      act = {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata};
      if (!rst && (mem_read || mem_write)) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          cur = act;
          if (exp_grant.size() == 0) check("grant_unexpected", 72'(mem_read | mem_write), 72'(0));
          else begin
            src = exp_grant.pop_front();
            grant_log.push_back(src);
            if (src == 1) begin
              if (exp_d_req.size() == 0) check("d_request_missing", 72'(act), 72'(0));
              else check("d_request", 72'(act), 72'(exp_d_req.pop_front()));
            end else begin
              if (exp_i_req.size() == 0) check("i_request_missing", 72'(act), 72'(0));
              else check("i_request", 72'(act), 72'(exp_i_req.pop_front()));
            end
          end
        end else check("hold_stable", 72'(act), 72'(cur));
      end else in_txn = 1'b0;
      // reference arbitration for the decision taken at the coming edge
      if (rst) begin
        m_busy = 1'b0; streak_m = 0; exp_grant.delete();
      end else if (m_busy) begin
        if (mem_resp) m_busy = 1'b0;
        if (!i_read) streak_m = 0;
      end else begin
        dq = d_read | d_write;
        ie = i_read & ~flush;
        if (dq || ie) begin
          src = (dq && !(ie && streak_m == MAXS)) ? 1 : 0;
          exp_grant.push_back(src);
          m_busy = 1'b1;
          if (src == 1 && i_read) streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
          else streak_m = 0;
        end else if (!i_read) streak_m = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input int port);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!((port == 1) ? d_resp : i_resp) && n < 60);
    check(port == 1 ? "d_resp_timeout" : "i_resp_timeout", 72'(port == 1 ? d_resp : i_resp), 72'(1));
    step();
  endtask

  task automatic wait_mem();
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(mem_read || mem_write) && n < 60);
    check("mem_req_timeout", 72'(mem_read | mem_write), 72'(1));
    step();
  endtask

  task automatic push_i(input logic [31:0] a, input logic want_resp);
    exp_i_req.push_back('{rd: 1'b1, wr: 1'b0, be: 4'hF, addr: a, wdata: 32'h0});
    if (want_resp) exp_i_rd.push_back(rd_fn(a));
  endtask

  task automatic push_d(input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd, input logic want_resp);
    exp_d_req.push_back('{rd: rd & ~wr, wr: wr, be: be, addr: a, wdata: wd});
    if (want_resp) exp_d_rd.push_back(rd_fn(a));
  endtask

  task automatic fetch_txn(input logic [31:0] a);
    push_i(a, 1'b1);
    i_address = a; i_read = 1'b1;
    wait_resp(0);
    i_read = 1'b0;
  endtask

  task automatic lsq_txn(input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
    push_d(rd, wr, be, a, wd, 1'b1);
    d_read = rd; d_write = wr; d_byte_enable = be; d_address = a; d_wdata = wd;
    wait_resp(1);
    d_read = 1'b0; d_write = 1'b0;
  endtask

  initial begin : stimulus
    int n0, n;
    int pat[6];
    rst = 1'b1; flush = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; d_byte_enable = '0;
    repeat (2) step();
    @(negedge clk);
    check("rst_ctrl", 72'({mem_read, mem_write, busy, i_resp, d_resp}), 72'(0));
    check("rst_data", 72'({mem_byte_enable, mem_address, mem_wdata, i_rdata}), 72'(0));
    step();
    rst = 1'b0;
    step();
    check("idle_after_rst", 72'({busy, mem_read, mem_write, mem_address}), 72'(0));

    // single fetch with immediate memory response
    delay_mode = 0;
    fetch_txn(32'h60);
    @(negedge clk);
    check("busy_after_fetch", 72'(busy), 72'(0));
    step();

    // simultaneous fetch and LSQ read: LSQ first
    delay_mode = -1;
    n0 = grant_log.size();
    fork
      fetch_txn(32'h60);
      lsq_txn(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    join
    check("both_grants", 72'(grant_log.size() - n0), 72'(2));
    if (grant_log.size() >= n0 + 2)
      check("lsq_first", 72'({grant_log[n0], grant_log[n0 + 1]}), 72'({32'd1, 32'd0}));

    // streak bound: D, D, I, D, D, I
    repeat (2) step();
    pat = '{1, 1, 0, 1, 1, 0};
    n0 = grant_log.size();
    for (int j = 0; j < 6; j++)
      if (pat[j] == 1) push_d(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1);
      else push_i(32'h400, 1'b1);
    d_read = 1'b1; d_address = 32'h300; d_byte_enable = 4'hF; d_wdata = 32'h0;
    i_read = 1'b1; i_address = 32'h400;
    n = 0;
    while (grant_log.size() < n0 + 6 && n < 200) begin
      @(negedge clk); n++;
    end
    step();
    d_read = 1'b0; i_read = 1'b0;
    check("streak_grant_count", 72'(grant_log.size() - n0), 72'(6));
    if (grant_log.size() >= n0 + 6)
      for (int j = 0; j < 6; j++) check("streak_order", 72'(grant_log[n0 + j]), 72'(pat[j]));
    repeat (8) step();

    // write held stable while requester inputs change
    delay_mode = 5;
    push_d(1'b0, 1'b1, 4'b0011, 32'h500, 32'hDEAD_BEEF, 1'b1);
    d_write = 1'b1; d_byte_enable = 4'b0011; d_address = 32'h500; d_wdata = 32'hDEAD_BEEF;
    wait_mem();
    d_wdata = 32'h1234_5678; d_byte_enable = 4'hF; d_address = 32'h999;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!d_resp && n < 60);
    check("write_resp", 72'(d_resp), 72'(1));
    check("write_hold", 72'({mem_byte_enable, mem_wdata}), 72'({4'b0011, 32'hDEAD_BEEF}));
    step();
    d_write = 1'b0;
    step();

    // flush squashes an in-flight fetch but not an LSQ write
    delay_mode = 3;
    push_i(32'h200, 1'b0);
    i_read = 1'b1; i_address = 32'h200;
    wait_mem();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!mem_resp && n < 60);
    check("flush_mem_resp", 72'(mem_resp), 72'(1));
    check("flush_no_i_resp", 72'({i_resp, i_rdata}), 72'(0));
    step();
    i_read = 1'b0;
    step();
    push_d(1'b0, 1'b1, 4'hF, 32'h240, 32'hCAFE_0001, 1'b1);
    d_write = 1'b1; d_address = 32'h240; d_wdata = 32'hCAFE_0001; d_byte_enable = 4'hF;
    wait_mem();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_resp(1);
    d_write = 1'b0;
    step();

    // reset aborts an LSQ write without a response
    delay_mode = 8;
    push_d(1'b0, 1'b1, 4'hF, 32'h700, 32'h0BAD_F00D, 1'b0);
    d_write = 1'b1; d_address = 32'h700; d_wdata = 32'h0BAD_F00D;
    wait_mem();
    rst = 1'b1; d_write = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort", 72'({mem_write, busy, d_resp}), 72'(0));
    repeat (10) step();
    delay_mode = -1;
    fetch_txn(32'h60);
    step();

    // randomized concurrent traffic
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) step();
          fetch_txn($urandom & 32'hFFFF_FFFC);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          logic [1:0] op;
          repeat ($urandom_range(0, 3)) step();
          op = 2'($urandom_range(1, 3));
          lsq_txn(op[0], op[1], 4'($urandom), $urandom, $urandom);
        end
      end
    join
    repeat (10) step();
    check("leftover_exp", 72'(exp_i_req.size() + exp_d_req.size() + exp_i_rd.size() + exp_d_rd.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between two requesters: the instruction fetcher (read-only) and the load/store queue (read/write).
- Sits between the cpu top level and the memory/cache.
- Grants one transaction at a time and holds a registered copy of the granted request on the downstream port.
- Data-side (LSQ) requests have priority over fetch, bounded by an anti-starvation streak counter.
- Supports a flush that squashes an in-flight fetch response.

Parameters:
- width, 32, data/address width.
- max_d_streak, 4, maximum consecutive LSQ grants while a fetch is pending; range 1–15.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush; squashes fetch traffic.
- i_read  input  1  fetch read request, held until i_resp.
- i_address  input  width  fetch address.
- i_resp  output  1  fetch transaction complete, 1-cycle pulse.
- i_rdata  output  width  fetch read data, valid with i_resp.
- d_read  input  1  LSQ read request, held until d_resp.
- d_write  input  1  LSQ write request, held until d_resp.
- d_byte_enable  input  width/8  LSQ byte enables.
- d_address  input  width  LSQ address.
- d_wdata  input  width  LSQ write data.
- d_resp  output  1  LSQ transaction complete, 1-cycle pulse.
- d_rdata  output  width  LSQ read data, valid with d_resp.
- mem_read  output  1  downstream read.
- mem_write  output  1  downstream write.
- mem_byte_enable  output  width/8  downstream byte enables.
- mem_address  output  width  downstream address.
- mem_wdata  output  width  downstream write data.
- mem_resp  input  1  downstream completion.
- mem_rdata  input  width  downstream read data.
- busy  output  1  state != IDLE.

Behaviour:
- Reset is synchronous, active-high rst on clk.
- Reset values:
  - state = IDLE.
  - streak = 0.
  - drop = 0.
  - All latched request registers = 0.
  - All outputs = 0.
- rst in any state aborts the transaction immediately. No resp pulse is issued. The downstream request deasserts the next cycle.
- States:
  - IDLE: no downstream request.
  - SERVE_I: fetch transaction outstanding.
  - SERVE_D: LSQ transaction outstanding.
- IDLE arbitration (d_req = d_read | d_write):
  - fetch eligible = i_read & ~flush.
  - d_req & eligible fetch & streak == max_d_streak → grant fetch.
  - Else d_req → grant LSQ.
  - Else eligible fetch → grant fetch.
  - Else stay in IDLE.
- Grant latches address, byte enables, wdata and read/write of the winner into registers and moves to SERVE_x.
  - The fetch byte enable latches as all ones.
  - The fetch write latches as 0.
- mem_* outputs are driven only from the registers while in SERVE_x. They are zero in IDLE and stable for the whole transaction.
- d_read & d_write both high: write wins, read is ignored.
- Streak counter:
  - LSQ grant while i_read high: streak + 1, saturating at max_d_streak.
  - Fetch grant, or any cycle with i_read low: streak = 0.
- Completion:
  - In SERVE_x with mem_resp = 1, assert x_resp combinationally the same cycle.
  - x_rdata = mem_rdata in that cycle; 0 otherwise.
  - Next state is IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle N → mem_read/mem_write high at N+1.
  - Earliest x_resp is at N+1.
  - One idle cycle separates transactions, so the minimum is 2 cycles per transaction.
- Flush:
  - flush in SERVE_I, or on the SERVE_I grant cycle, sets drop.
  - The downstream read completes normally, but i_resp is suppressed.
  - drop clears on returning to IDLE.
- flush never affects SERVE_D. LSQ writes must not be lost.
- mem_resp while in IDLE is ignored.

Test Plan:
- Single fetch i_read = 1, i_address = 0x60 → mem_read = 1 with mem_address = 0x60 next cycle. mem_resp = 1 with mem_rdata = 0x00000013 → i_resp = 1 with i_rdata = 0x13 in the same cycle; busy returns to 0.
- i_read and d_read asserted together, d_address = 0x100 → LSQ served first (mem_address = 0x100), then fetch; d_resp precedes i_resp.
- max_d_streak = 2, d_read held continuously, i_read held → grant order D, D, I, D, D, I.
- LSQ write with d_wdata = 0xDEADBEEF, d_byte_enable = 0b0011 and a 5-cycle mem_resp delay; inputs change after grant → mem_wdata and mem_byte_enable stay 0xDEADBEEF/0b0011 until mem_resp.
- flush pulsed during SERVE_I → mem_read completes and mem_resp accepted, but i_resp stays 0. An LSQ transaction with flush pulsed still yields d_resp.
- rst asserted during SERVE_D → next cycle mem_write = 0, busy = 0, no d_resp; a subsequent fetch is granted normally.
